// File: rtl/collision_detect.sv
// Pac-Man map collision classifier and pill tracker.
// Reports wall/pill/empty for the candidate cell one clock later and consumes pills on detection.
module collision_detect (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        colli_clr,
  input  logic [5:0]  next_pacman_x,
  input  logic [4:0]  next_pacman_y,
  output logic [3:0]  collision_type,
  output logic [32:0] pill_count
);

  typedef enum logic [3:0] {
    COLL_NONE = 4'b0000,
    COLL_WALL = 4'b0001,
    COLL_PILL = 4'b0010
  } coll_e;

  localparam int unsigned MAP_W = 40;
  localparam int unsigned MAP_H = 30;
  localparam int unsigned CELLS = MAP_W * MAP_H;

  function automatic logic is_wall(input logic [5:0] x, input logic [4:0] y);
    is_wall = (x >= 6'd40) || (y >= 5'd30) ||
              (x == 6'd0) || (x == 6'd39) || (y == 5'd0) || (y == 5'd29) ||
              ((y == 5'd5) && (x >= 6'd10) && (x <= 6'd29)) ||
              ((x == 6'd10) && (y >= 5'd10) && (y <= 5'd20));
  endfunction

  // Every non-wall cell starts with a pill except the Pac-Man start cell (20,20).
  function automatic logic [CELLS-1:0] init_map();
    logic [CELLS-1:0] m;
    m = '0;
    for (int unsigned yy = 0; yy < MAP_H; yy++) begin
      for (int unsigned xx = 0; xx < MAP_W; xx++) begin
        m[yy*MAP_W + xx] = !is_wall(6'(xx), 5'(yy)) && !((xx == 20) && (yy == 20));
      end
    end
    return m;
  endfunction

  localparam logic [CELLS-1:0] PILL_INIT = init_map();

  logic [CELLS-1:0] pill_q, pill_d;
  coll_e            coll_q, coll_d;
  logic [32:0]      count_q, count_d;
  logic             wall;
  logic [10:0]      cell_idx;

  always_comb begin
    wall = is_wall(next_pacman_x, next_pacman_y);
    // Off-map coordinates are walls and must never reach the array index.
    cell_idx = wall ? '0 : ({6'd0, next_pacman_y} * 11'd40 + {5'd0, next_pacman_x});

    pill_d  = pill_q;
    count_d = count_q;
    coll_d  = COLL_NONE;

    if (reset) begin
      pill_d  = PILL_INIT;
      count_d = '0;
    end else if (colli_clr) begin
      coll_d = COLL_NONE;
    end else if (wall) begin
      coll_d = COLL_WALL;
    end else if (pill_q[cell_idx]) begin
      coll_d           = COLL_PILL;
      pill_d[cell_idx] = 1'b0;
      count_d          = count_q + 33'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    pill_q  <= pill_d;
    coll_q  <= coll_d;
    count_q <= count_d;
  end

  assign collision_type = coll_q;
  assign pill_count     = count_q;

endmodule

// File: tb/tb_collision_detect.sv
// Scoreboard bench for collision_detect: directed scenarios plus random probes
// checked against a cell-array model of the game map.
module tb_collision_detect;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        colli_clr = 1'b0;
  logic [5:0]  nx = '0;
  logic [4:0]  ny = '0;
  logic [3:0]  collision_type;
  logic [32:0] pill_count;

  int checks = 0;
  int failures = 0;

  logic [3:0]  exp_type_q[$];
  logic [32:0] exp_cnt_q[$];

  bit pill [0:39][0:29];
  int model_cnt = 0;

  collision_detect dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .colli_clr     (colli_clr),
    .next_pacman_x (nx),
    .next_pacman_y (ny),
    .collision_type(collision_type),
    .pill_count    (pill_count)
  );

  always #5 clk = ~clk;

  function automatic bit m_wall(int x, int y);
    if (x >= 40 || y >= 30) return 1;
    if (x == 0 || x == 39 || y == 0 || y == 29) return 1;
    if (y == 5 && x >= 10 && x <= 29) return 1;
    if (x == 10 && y >= 10 && y <= 20) return 1;
    return 0;
  endfunction

  task automatic m_restore();
    for (int x = 0; x < 40; x++)
      for (int y = 0; y < 30; y++)
        pill[x][y] = !m_wall(x, y) && !(x == 20 && y == 20);
    model_cnt = 0;
  endtask

  // One clock of stimulus; the expected response for the following edge is queued.
  task automatic step(input int x, input int y, input bit clr, input bit rst);
    logic [3:0] et;
    @(negedge clk);
    nx = 6'(x);
    ny = 5'(y);
    colli_clr = clr;
    reset = rst;
    et = 4'b0000;
    if (rst) m_restore();
    else if (clr) et = 4'b0000;
    else if (m_wall(x, y)) et = 4'b0001;
    else if (pill[x][y]) begin
      et = 4'b0010;
      pill[x][y] = 0;
      model_cnt++;
    end
    exp_type_q.push_back(et);
    exp_cnt_q.push_back(33'(model_cnt));
  endtask

  task automatic check_count(input string name, input int want);
    @(posedge clk);
    #2;
    checks++;
    if (pill_count !== 33'(want)) begin
      failures++;
      $display("FAIL %s: pill_count=%0d expected=%0d", name, pill_count, want);
    end
  endtask

  initial begin : monitor
    logic [3:0]  et;
    logic [32:0] ec;
    forever begin
      @(posedge clk);
      #1;
      if (exp_type_q.size() > 0) begin
        et = exp_type_q.pop_front();
        ec = exp_cnt_q.pop_front();
        checks++;
        if (collision_type !== et) begin
          failures++;
          $display("FAIL collision_type @%0t: got=%b expected=%b", $time, collision_type, et);
        end
        checks++;
        if (pill_count !== ec) begin
          failures++;
          $display("FAIL pill_count @%0t: got=%0d expected=%0d", $time, pill_count, ec);
        end
      end
    end
  end

  initial begin : stimulus
    int wx[$];
    int wy[$];
    m_restore();
    step(20, 20, 0, 1);
    step(20, 20, 0, 0);
    step(20, 19, 0, 0);
    step(20, 19, 0, 0);
    step(0, 12, 0, 0);
    step(39, 3, 0, 0);
    step(15, 5, 0, 0);
    step(10, 15, 0, 0);
    step(45, 3, 0, 0);
    step(20, 31, 0, 0);
    step(63, 31, 0, 0);
    step(20, 18, 1, 0);
    step(20, 18, 0, 0);
    step(20, 18, 0, 0);

    // Walk from a fresh map, holding each cell for 9 cycles.
    step(20, 20, 0, 1);
    for (int y = 19; y >= 9; y--) begin wx.push_back(20); wy.push_back(y); end
    for (int x = 19; x >= 14; x--) begin wx.push_back(x); wy.push_back(9); end
    for (int y = 10; y <= 16; y++) begin wx.push_back(14); wy.push_back(y); end
    foreach (wx[i])
      for (int k = 0; k < 9; k++) step(wx[i], wy[i], 0, 0);
    check_count("walk_total", 24);

    step(14, 16, 0, 1);
    step(20, 19, 0, 0);
    check_count("after_reset_reprobe", 1);

    for (int i = 0; i < 3000; i++) begin
      int x, y;
      bit clr, rst;
      if ($urandom_range(0, 9) == 0) begin
        x = $urandom_range(0, 63);
        y = $urandom_range(0, 31);
      end else begin
        x = $urandom_range(0, 39);
        y = $urandom_range(0, 29);
      end
      clr = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step(x, y, clr, rst);
      if ($urandom_range(0, 3) == 0) step(x, y, clr, 0);
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_type_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_type_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/collision_detect.md
Name: collision_detect

Overview:
- Game-map collision and pill-tracking block for the Pac-Man FPGA game.
- The location controller drives the candidate next Pac-Man cell. One cycle later, this block reports what occupies that cell: wall, pill or empty.
- Pills are consumed on detection. The block keeps a running count of pills eaten.
- Holds the authoritative pill map: 40 columns x 30 rows.

Parameters:
- None. The map is fixed: 40 x 30 cells, start cell (20,20).

Ports:
- CLOCK_50  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; clock CLOCK_50
- colli_clr  input  1  clear request: forces collision_type to none and suppresses pill consumption
- next_pacman_x  input  6  candidate cell column (0..63; only 0..39 on-map)
- next_pacman_y  input  5  candidate cell row (0..31; only 0..29 on-map)
- collision_type  output  4  registered classification of the candidate cell
- pill_count  output  33  total pills eaten since reset

Behaviour:
- Encodings for collision_type:
  - 4'b0000 = empty / none
  - 4'b0001 = wall
  - 4'b0010 = pill
  - all other codes are never produced.
- Wall map (combinational from coordinates). A cell is a wall when any of these hold:
  - x >= 40 or y >= 30 (off-map is treated as wall)
  - x == 0, x == 39, y == 0 or y == 29 (border)
  - y == 5 and 10 <= x <= 29 (horizontal segment)
  - x == 10 and 10 <= y <= 20 (vertical segment)
- Pill map: 1200-bit register array, one bit per on-map cell.
  - Reset value: 1 on every non-wall cell except the start cell (20,20), which is 0.
  - 1032 pills total at reset.
  - Wall cells always hold 0.
- Per rising edge, in priority order:
  1. reset: restore the pill map, collision_type <= 0000, pill_count <= 0.
  2. colli_clr: collision_type <= 0000. Pill map and count unchanged.
  3. Cell is a wall: collision_type <= 0001. No map change.
  4. Pill bit set at (x,y): collision_type <= 0010, clear that bit, pill_count <= pill_count + 1. All three happen in the same edge.
  5. Otherwise: collision_type <= 0000.
- Latency: one clock. The output reflects the coordinates sampled at the previous edge. The consumer waits at least one cycle after changing coordinates before reading.
- Holding the same coordinates:
  - The pill is eaten exactly once.
  - The following cycle reports 0000 and the count is unchanged.
  - Wall results repeat every cycle.
- No handshake. Coordinates are sampled every cycle regardless of the consumer's state.
- pill_count cannot exceed 1032, so no wrap or saturation logic is needed. Upper bits stay 0.
- colli_clr unconnected or tied low gives normal operation.
- Reset mid-operation: a reset asserted on any cycle takes effect at that edge. All eaten pills are restored.
- Coordinate inputs are unregistered by this block. Out-of-range coordinates must never index the pill array: they are classified as wall before any lookup.

Test Plan:
- Reset, then drive (20,20) -> after 1 edge: collision_type=0000, pill_count=0.
- Drive (20,19) -> next edge: 0010, pill_count=1. Hold (20,19) one more edge -> 0000, pill_count stays 1.
- Wall probes, each giving 0001 with pill_count unchanged:
  - (0,12), (39,3), (15,5), (10,15) (map walls)
  - (45,3), (20,31) (off-map)
- colli_clr=1 with (20,18) -> 0000, count unchanged. Release colli_clr -> next edge 0010, count +1.
- Walk sequence (20,19)..(20,9), then (19,9)..(14,9), then (14,10)..(14,16), one cell per 9 cycles -> every first probe reports 0010, none 0001. Final pill_count=24.
- After eating pills, assert reset for one edge. Re-probe (20,19) -> 0010, and pill_count goes 0 -> 1.
